// File: rtl/pss_ref_streamer.sv
// pss_ref_streamer
// Read sequencer and output buffer for the PSS reference ROM. Walks the ROM
// address space, captures the 1-cycle-latency ROM data into a 2-entry FIFO
// and presents the reference samples as a valid/ready stream to the PSS
// correlator. Supports a single pass or continuous wrap-around passes.
//
// Ports:
//   iclk, irst        clock, synchronous active-high reset
//   istart, icont     start pulse and continuous-mode select (sampled in IDLE)
//   istop             in continuous mode, stop after the current pass
//   orom_addr/orom_val ROM read address / read enable
//   irom_dat          ROM read data, valid the cycle after a read
//   odat/oval/iready  output stream data / valid / ready
//   olast             marks the word read from the final ROM address
//   obusy             high while a pass is running or draining
//   odone             one-cycle pulse once the stream has fully drained
module pss_ref_streamer #(
  parameter int pDAT_W   = 72,
  parameter int pDAT_Num = 1024,
  parameter int pADDR_W  = 11
) (
  input  logic               iclk,
  input  logic               irst,
  input  logic               istart,
  input  logic               icont,
  input  logic               istop,
  output logic [pADDR_W-1:0] orom_addr,
  output logic               orom_val,
  input  logic [pDAT_W-1:0]  irom_dat,
  output logic [pDAT_W-1:0]  odat,
  output logic               oval,
  input  logic               iready,
  output logic               olast,
  output logic               obusy,
  output logic               odone
);

  localparam logic [pADDR_W-1:0] LAST_ADDR = pADDR_W'(pDAT_Num - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q;
  logic [pADDR_W-1:0]  addr_q;
  logic                cont_q;
  logic                stop_q;
  logic                inflight_q;
  logic                inflightLast_q;
  logic [pDAT_W-1:0]   memDat_q [2];
  logic                memLast_q [2];
  logic                rdPtr_q;
  logic                wrPtr_q;
  logic [1:0]          fifoCnt_q;
  logic [1:0]          fifoCnt_d;

  logic pop;
  logic credit;
  logic issue;
  logic isLastAddr;
  logic drained;

  // Credit check: words already buffered plus the one in flight, less the
  // word leaving this cycle, must leave room in the 2-entry FIFO. Counting
  // the pop lets a fully streaming pipe issue one read every cycle.
  always_comb begin
    pop        = oval & iready;
    credit     = ({1'b0, fifoCnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    issue      = (state_q == RUN) & credit;
    isLastAddr = (addr_q == LAST_ADDR);
    drained    = (state_q == DRAIN) & ~inflight_q & (fifoCnt_q == 2'd0);
    fifoCnt_d  = fifoCnt_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  assign orom_addr = addr_q;
  assign orom_val  = issue;
  assign oval      = (fifoCnt_q != 2'd0);
  assign odat      = memDat_q[rdPtr_q];
  assign olast     = memLast_q[rdPtr_q];
  assign obusy     = (state_q != IDLE);
  assign odone     = drained;

  // Sequencer FSM, in-flight tracking and the output FIFO. Each ROM read
  // carries a last-address flag that lands in the FIFO with its data.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      cont_q         <= 1'b0;
      stop_q         <= 1'b0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      rdPtr_q        <= 1'b0;
      wrPtr_q        <= 1'b0;
      fifoCnt_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        memDat_q[i]  <= '0;
        memLast_q[i] <= 1'b0;
      end
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflightLast_q <= isLastAddr;
      end

      if (inflight_q) begin
        memDat_q[wrPtr_q]  <= irom_dat;
        memLast_q[wrPtr_q] <= inflightLast_q;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      fifoCnt_q <= fifoCnt_d;

      case (state_q)
        IDLE: begin
          addr_q <= '0;
          cont_q <= icont;
          stop_q <= 1'b0;
          if (istart) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (istop) begin
            stop_q <= 1'b1;
          end
          if (issue) begin
            if (isLastAddr) begin
              if (cont_q && !stop_q) begin
                addr_q <= '0;
              end else begin
                state_q <= DRAIN;
              end
            end else begin
              addr_q <= addr_q + pADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drained) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pss_ref_streamer.md
# pss_ref_streamer

Read sequencer and output buffer for the PSS reference ROM in the sync IP. Issues `addr`/`ival` reads to the ROM and captures its 1-cycle-latency `odat`. Delivers the reference samples as a valid/ready stream to the PSS correlator, with full backpressure and single-pass or continuous (wrap-around) modes.

## Interface
- `pDAT_W`, 72: ROM word width; also the width of the stream data.
- `pDAT_Num`, 1024: number of ROM words per pass, from 2 to 2^pADDR_W.
- `pADDR_W`, 11: ROM address width.
- `iclk` in 1: clock. One clock domain only.
- `irst` in 1: reset, synchronous, active-high.
- `istart` in 1: start pulse; sampled only in IDLE.
- `icont` in 1: continuous mode; sampled together with `istart`.
- `istop` in 1: in continuous mode, finish the current pass and then stop.
- `orom_addr` out pADDR_W: ROM read address.
- `orom_val` out 1: ROM read enable; drives the ROM `ival`.
- `irom_dat` in pDAT_W: ROM `odat`. Valid on the cycle after the read; held while `orom_val`=0.
- `odat` out pDAT_W: stream data.
- `oval` out 1: stream valid.
- `iready` in 1: stream ready.
- `olast` out 1: marks the word read from address pDAT_Num-1.
- `obusy` out 1: high in RUN and DRAIN.
- `odone` out 1: one-cycle pulse when the stream is fully drained.

## Operation
- FSM states are IDLE, RUN and DRAIN.
- IDLE:
  - `istart`=1 moves to RUN.
  - Read address resets to 0; `cont_q` ← `icont`; `stop_q` ← 0.
- RUN:
  - A read is issued (`orom_val`=1, `orom_addr`=addr) when `fifo_cnt + inflight - pop < 2`, where `pop = oval & iready`.
  - Each issue increments addr.
  - After issuing addr pDAT_Num-1:
    - if `cont_q` & !`stop_q`, addr wraps to 0 and RUN continues;
    - otherwise the FSM goes to DRAIN.
  - `istop` sets `stop_q`; it has no effect when `cont_q`=0.
- DRAIN: no reads. When `inflight`=0, `fifo_cnt`=0 and no pop is pending, pulse `odone` and go to IDLE.
- `istart` is ignored in RUN and DRAIN.
- `inflight` (0/1) is set on the issue cycle. On the next cycle `irom_dat` is written into the 2-entry output FIFO and `inflight` clears.
- A flag bit travels with each read and marks address pDAT_Num-1; it is stored alongside the data in the FIFO and drives `olast`.
- The FIFO is 2 entries, storing data and the last flag. Its head drives `odat`/`olast`; `oval` = (`fifo_cnt` > 0).
- Simultaneous write and pop is allowed at any count; `fifo_cnt` is unchanged.
- The FIFO never overflows; the credit rule guarantees this.
- Stream rules:
  - While `oval`=1 & `iready`=0, `odat` and `olast` are stable.
  - `oval` never drops without a pop.
- Reset:
  - `irst` returns the FSM to IDLE and zeroes addr, `inflight`, `fifo_cnt`, `cont_q` and `stop_q`.
  - Any ROM word still in flight is discarded.
- Output reset values: `orom_addr`=0, `orom_val`=0, `odat`=0, `oval`=0, `olast`=0, `obusy`=0, `odone`=0.

## Timing
- `istart` sampled at the edge ending cycle 0:
  - cycle 1: state RUN, `obusy`=1, `orom_val`=1, `orom_addr`=0;
  - cycle 2: ROM data available on `irom_dat`;
  - cycle 3: `oval`=1, `odat`=rom[0].
- Start-to-first-valid latency is 3 cycles.
- With `iready` held high, throughput is 1 word/cycle; there are no bubbles between passes in continuous mode.
- Single pass with `iready`=1:
  - last issue in cycle pDAT_Num;
  - `olast` in cycle pDAT_Num+2;
  - `odone` in cycle pDAT_Num+3;
  - IDLE from cycle pDAT_Num+4.
- `istart` may be accepted again in the cycle after `odone`.
- `iready`=0 stalls issuing within at most 1 cycle. At most 2 words are buffered; no data is lost or repeated.
- `irst` asserted in any cycle: all outputs take their reset values in the following cycle.

## Test plan
- **Single pass, ROM model rom[i]=i, pDAT_Num=1024, `iready`=1, pulse `istart`:** expect 1024 words 0..1023 on consecutive cycles with first `oval` 3 cycles after `istart`, `olast` only with 1023, then one `odone` pulse and `obusy` low.
- **Random backpressure:** `iready` random at 50%. Expect the exact sequence 0..1023 with no gaps, duplicates or reorders, and `odat` stable whenever `oval`&!`iready`. `orom_val` is never issued with `fifo_cnt+inflight`=2 and no pop.
- **Continuous mode:** `icont`=1, then `istop` pulsed during the 3rd pass. Expect 3 complete passes (3072 words), `olast` on each word 1023, the wrap 1023→0 with no bubble, then `odone`.
- **`istart` during RUN/DRAIN:** pulse `istart` during RUN and again during DRAIN. Expect them ignored and exactly one pass output.
- **Mid-stream reset:** `irst` at word 500 with `iready`=0 and the FIFO full. Expect all outputs at reset values on the next cycle. A fresh `istart` restarts from rom[0].
- **Back-to-back restart:** `istart` in the cycle after `odone`. Expect the second pass to start with correct latency and `olast` timing.
